mips_run_ctrl: RTL and testbench
================================

# mips_run_ctrl

Execution and load sequencer for the single-cycle MIPS core on the FPGA board. It turns debounced push-button pulses into a one-cycle CPU clock-enable for single-step or paced free-run, and holds the core in reset while a loader writes instruction words into instruction memory. The block sits between the button debouncer and the core, and feeds a state code to the LEDs.

## Interface
Parameters:
- TICK_DIV, default 12_500_000: CLK cycles per free-run step (4 Hz at 50 MHz). Must be ≥ 2.
- IMEM_AW, default 8: instruction-memory word-address width.

Ports:
- CLK  in  1  system clock; the only clock.
- RST  in  1  reset, synchronous, active-high.
- BSTEP  in  1  one-cycle pulse from the debouncer: execute one instruction.
- BRUN  in  1  one-cycle pulse: toggle run/pause.
- BLOAD  in  1  one-cycle pulse: enter or leave load mode.
- LD_WR  in  1  one-cycle pulse: write W_Ins at the current load address.
- W_Ins  in  32  instruction word to load.
- BRK  in  1  level from core decode: the current instruction is a break.
- CPU_EN  out  1  one-cycle enable; the core advances PC and commits state only when this is high.
- CPU_RST  out  1  core reset; high for every cycle in LOAD.
- IM_WE  out  1  instruction-memory write strobe.
- IM_WA  out  IMEM_AW  instruction-memory write address.
- IM_WD  out  32  instruction-memory write data.
- LD_FULL  out  1  every address has been written since LOAD entry.
- STATE  out  2  0=IDLE, 1=RUN, 2=HALT, 3=LOAD.
- ICNT  out  16  count of issued CPU_EN pulses; saturates at 0xFFFF.

## Operation
- All outputs are registered.
- Reset values: STATE=IDLE. CPU_EN, CPU_RST, IM_WE, LD_FULL = 0. IM_WA, IM_WD, ICNT, prescaler = 0.
- Pulse priority within one cycle: BLOAD > BRUN > BSTEP > LD_WR. All lower-priority pulses in that cycle are dropped.
- IDLE:
  - BLOAD → LOAD.
  - BRUN → RUN; prescaler cleared.
  - BSTEP with BRK=0 → one CPU_EN pulse; state stays IDLE.
  - BSTEP with BRK=1 → HALT; no CPU_EN.
- RUN:
  - Prescaler counts 0..TICK_DIV-1 and wraps.
  - At terminal count: if BRK=0, one CPU_EN pulse; if BRK=1, go to HALT with no CPU_EN.
  - BRUN → IDLE; BLOAD → LOAD; BSTEP ignored.
- HALT:
  - CPU_EN is never asserted; BSTEP and BRUN are ignored.
  - Only BLOAD or RST leaves this state.
- LOAD:
  - CPU_RST=1 in every LOAD cycle.
  - On entry: load address := 0, LD_FULL := 0, ICNT := 0.
  - LD_WR with LD_FULL=0: IM_WE=1 for one cycle with IM_WA=address and IM_WD=W_Ins; address then increments.
  - An increment that wraps from 2^IMEM_AW-1 to 0 sets LD_FULL. While LD_FULL=1, LD_WR is ignored and IM_WE stays 0.
  - BLOAD → IDLE; CPU_RST is 0 from that next cycle on. BSTEP and BRUN are ignored in LOAD.
- ICNT increments on each issued CPU_EN and holds at 0xFFFF.
- RST asserted mid-operation (e.g. during a write) forces reset values on the next edge. No partial write is retried.

## Timing
- Pulse in cycle N → CPU_EN, IM_WE or state change visible in cycle N+1.
- CPU_EN is exactly one cycle wide and never high in two consecutive cycles.
- In RUN, enables are spaced exactly TICK_DIV cycles apart. The first enable comes TICK_DIV cycles after the state changes to RUN.
- BRK is sampled in the same cycle as the BSTEP pulse or prescaler terminal count.
- IM_WA and IM_WD are stable during, and only change with, IM_WE.
- LD_FULL rises in the same cycle as the last IM_WE.

## Structure
- Package mips_ctrl_pkg holds the STATE encoding constants (IDLE/RUN/HALT/LOAD) and the ICNT width.
- One sub-module, tick_div: a parameterised prescaler with synchronous clear, emitting a one-cycle terminal-count pulse. The FSM, loader address counter and ICNT live in mips_run_ctrl.

## Test plan
All scenarios use TICK_DIV=4, IMEM_AW=2.
- Reset, then 3 BSTEP pulses spaced 5 cycles apart, BRK=0 → three single-cycle CPU_EN pulses, each 1 cycle after its pulse; ICNT=3; STATE=0.
- BRUN, wait 20 cycles, BRUN → CPU_EN at 4, 8, 12, 16 and 20 cycles after the state change to RUN; then STATE=0 and no further enables.
- RUN with BRK raised before the 2nd terminal count → exactly one CPU_EN, then STATE=2. BSTEP and BRUN produce no enables afterwards.
- BLOAD, then 5 LD_WR pulses with W_Ins = 0x11..0x55 → writes 0x11@0, 0x22@1, 0x33@2, 0x44@3; LD_FULL rises with the 4th write; the 5th pulse gives no IM_WE; CPU_RST=1 throughout; after BLOAD, STATE=0 and CPU_RST=0.
- BLOAD and BSTEP in the same cycle from IDLE → STATE=3, no CPU_EN. RST asserted during LOAD → all reset values next cycle.
- Run until ICNT reaches 0xFFFF (force the counter via hierarchical deposit), then one more BSTEP → CPU_EN issued, ICNT stays 0xFFFF.

Source files
------------

// File: rtl/mips_ctrl_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : mips_ctrl_pkg
//  Purpose  : Shared definitions for the MIPS run/load sequencer: the STATE
//             code presented on the LEDs and the instruction-count width.
//  Contents : run_state_t  - 2-bit state encoding (IDLE/RUN/HALT/LOAD)
//             c_icnt_w     - width of the issued-instruction counter
//             c_icnt_max   - saturation value of that counter
//  Revision : 1.0  initial release
// ============================================================================
package mips_ctrl_pkg;

    // Width of the issued-enable counter and the value at which it sticks.
    localparam int                  c_icnt_w   = 16;
    localparam logic [c_icnt_w-1:0] c_icnt_max = '1;

    // The numeric values are visible externally on the STATE port, so they
    // are pinned explicitly rather than left to enum auto-numbering.
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_HALT = 2'd2,
        ST_LOAD = 2'd3
    } run_state_t;

endpackage : mips_ctrl_pkg
`default_nettype wire

// File: rtl/mips_run_ctrl_tick_div.sv
`default_nettype none
// ============================================================================
//  Module   : tick_div
//  Purpose  : Free-run pacing prescaler. Counts 0..TICK_DIV-1 while enabled
//             and wraps; tc is high for the single cycle in which the count
//             sits at its terminal value.
//  Ports    : clk - system clock
//             rst - synchronous active-high reset (count := 0)
//             clr - synchronous clear (count := 0), same effect as rst
//             en  - count enable; when low the count holds and tc is low
//             tc  - terminal-count pulse (combinational from the count reg)
//  Revision : 1.0  initial release
// ============================================================================
module tick_div #(
    parameter int TICK_DIV = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic en,
    output logic tc
);

    localparam int                 c_cnt_w = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [c_cnt_w-1:0] c_last  = c_cnt_w'(TICK_DIV - 1);

    logic [c_cnt_w-1:0] r_cnt;
    logic               w_at_last;

    assign w_at_last = (r_cnt == c_last);

    always_ff @(posedge clk) begin
        if (rst || clr) begin
            r_cnt <= '0;
        end else if (en) begin
            r_cnt <= w_at_last ? '0 : r_cnt + 1'b1;
        end
    end

    // Gated by en so a paused prescaler parked at its last value cannot
    // produce a stray tick.
    assign tc = en && w_at_last;

endmodule : tick_div
`default_nettype wire

// File: rtl/mips_run_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : mips_run_ctrl
//  Purpose  : Execution and load sequencer for the single-cycle MIPS core.
//             Converts debounced button pulses into a one-cycle CPU enable
//             (single step or paced free run) and holds the core in reset
//             while instruction words are streamed into instruction memory.
//  Ports    : CLK     - system clock
//             RST     - synchronous active-high reset
//             BSTEP   - pulse: execute one instruction
//             BRUN    - pulse: toggle run / pause
//             BLOAD   - pulse: enter / leave load mode
//             LD_WR   - pulse: write W_Ins at the current load address
//             W_Ins   - instruction word to load
//             BRK     - level: current instruction is a break
//             CPU_EN  - one-cycle core advance enable
//             CPU_RST - core reset, high throughout LOAD
//             IM_WE   - instruction-memory write strobe
//             IM_WA   - instruction-memory write address
//             IM_WD   - instruction-memory write data
//             LD_FULL - every address written since LOAD entry
//             STATE   - 0=IDLE 1=RUN 2=HALT 3=LOAD
//             ICNT    - issued CPU_EN count, saturating
//  Revision : 1.0  initial release
// ============================================================================
module mips_run_ctrl
    import mips_ctrl_pkg::*;
#(
    parameter int TICK_DIV = 12_500_000,
    parameter int IMEM_AW  = 8
) (
    input  logic                CLK,
    input  logic                RST,
    input  logic                BSTEP,
    input  logic                BRUN,
    input  logic                BLOAD,
    input  logic                LD_WR,
    input  logic [31:0]         W_Ins,
    input  logic                BRK,
    output logic                CPU_EN,
    output logic                CPU_RST,
    output logic                IM_WE,
    output logic [IMEM_AW-1:0]  IM_WA,
    output logic [31:0]         IM_WD,
    output logic                LD_FULL,
    output logic [1:0]          STATE,
    output logic [c_icnt_w-1:0] ICNT
);

    // ------------------------------------------------------------------
    // Registered state and outputs
    // ------------------------------------------------------------------
    run_state_t          r_state;
    logic                r_cpu_en;
    logic                r_cpu_rst;
    logic                r_im_we;
    logic [IMEM_AW-1:0]  r_im_wa;
    logic [31:0]         r_im_wd;
    logic                r_ld_full;
    logic [IMEM_AW-1:0]  r_ld_addr;
    logic [c_icnt_w-1:0] r_icnt;

    // ------------------------------------------------------------------
    // Decoded pulses after priority resolution (BLOAD > BRUN > BSTEP > LD_WR)
    // ------------------------------------------------------------------
    logic w_tc;
    logic w_run_clr;
    logic w_load_entry;
    logic w_step_issue;
    logic w_run_issue;
    logic w_issue;
    logic w_wr;
    logic w_ld_last;

    // Prescaler is cleared on the IDLE->RUN transition so the first enable
    // lands exactly TICK_DIV cycles after STATE shows RUN.
    assign w_run_clr = (r_state == ST_IDLE) && !BLOAD && BRUN;

    tick_div #(
        .TICK_DIV (TICK_DIV)
    ) u_tick_div (
        .clk (CLK),
        .rst (RST),
        .clr (w_run_clr),
        .en  (r_state == ST_RUN),
        .tc  (w_tc)
    );

    assign w_load_entry = BLOAD && (r_state != ST_LOAD);

    // The r_cpu_en term keeps enables from ever touching back to back even
    // if the debouncer delivers BSTEP in adjacent cycles.
    assign w_step_issue = (r_state == ST_IDLE) && !BLOAD && !BRUN && BSTEP
                          && !BRK && !r_cpu_en;
    assign w_run_issue  = (r_state == ST_RUN) && !BLOAD && !BRUN && w_tc && !BRK;
    assign w_issue      = w_step_issue || w_run_issue;

    assign w_wr      = (r_state == ST_LOAD) && !BLOAD && LD_WR && !r_ld_full;
    assign w_ld_last = &r_ld_addr;

    // ------------------------------------------------------------------
    // FSM, loader and instruction counter
    // ------------------------------------------------------------------
    always_ff @(posedge CLK) begin
        if (RST) begin
            r_state   <= ST_IDLE;
            r_cpu_en  <= 1'b0;
            r_cpu_rst <= 1'b0;
            r_im_we   <= 1'b0;
            r_im_wa   <= '0;
            r_im_wd   <= '0;
            r_ld_full <= 1'b0;
            r_ld_addr <= '0;
            r_icnt    <= '0;
        end else begin
            r_cpu_en <= w_issue;
            r_im_we  <= w_wr;

            case (r_state)
                ST_IDLE: begin
                    if (BLOAD) begin
                        r_state   <= ST_LOAD;
                        r_cpu_rst <= 1'b1;
                    end else if (BRUN) begin
                        r_state <= ST_RUN;
                    end else if (BSTEP && BRK) begin
                        r_state <= ST_HALT;
                    end
                end
                ST_RUN: begin
                    if (BLOAD) begin
                        r_state   <= ST_LOAD;
                        r_cpu_rst <= 1'b1;
                    end else if (BRUN) begin
                        r_state <= ST_IDLE;
                    end else if (w_tc && BRK) begin
                        r_state <= ST_HALT;
                    end
                end
                ST_HALT: begin
                    // Sticky: only a load (or reset) recovers from a break.
                    if (BLOAD) begin
                        r_state   <= ST_LOAD;
                        r_cpu_rst <= 1'b1;
                    end
                end
                ST_LOAD: begin
                    if (BLOAD) begin
                        r_state   <= ST_IDLE;
                        r_cpu_rst <= 1'b0;
                    end else begin
                        r_cpu_rst <= 1'b1;
                    end
                end
                default: begin
                    r_state   <= ST_IDLE;
                    r_cpu_rst <= 1'b0;
                end
            endcase

            // Loader: address and data registers move only with a write so
            // the memory port sees stable values around the strobe.
            if (w_load_entry) begin
                r_ld_addr <= '0;
                r_ld_full <= 1'b0;
            end else if (w_wr) begin
                r_im_wa   <= r_ld_addr;
                r_im_wd   <= W_Ins;
                r_ld_addr <= r_ld_addr + 1'b1;
                // Full flag rises together with the strobe of the last slot.
                if (w_ld_last) begin
                    r_ld_full <= 1'b1;
                end
            end

            // Entry to LOAD and an issue are mutually exclusive because
            // BLOAD outranks every issuing pulse.
            if (w_load_entry) begin
                r_icnt <= '0;
            end else if (w_issue && (r_icnt != c_icnt_max)) begin
                r_icnt <= r_icnt + 1'b1;
            end
        end
    end

    assign CPU_EN  = r_cpu_en;
    assign CPU_RST = r_cpu_rst;
    assign IM_WE   = r_im_we;
    assign IM_WA   = r_im_wa;
    assign IM_WD   = r_im_wd;
    assign LD_FULL = r_ld_full;
    assign STATE   = r_state;
    assign ICNT    = r_icnt;

endmodule : mips_run_ctrl
`default_nettype wire

// File: tb/tb_mips_run_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : tb_mips_run_ctrl
//  Purpose  : Self-checking bench for mips_run_ctrl (TICK_DIV=4, IMEM_AW=2).
//             A cycle-level behavioural model predicts enables and memory
//             writes into queues; a negedge monitor pops and compares them
//             against the DUT and also compares the status outputs.
//  Revision : 1.0  initial release
// ============================================================================
module tb_mips_run_ctrl;

    localparam int T     = 4;
    localparam int AW    = 2;
    localparam int DEPTH = 1 << AW;

    logic          clk = 1'b0;
    logic          rst;
    logic          bstep, brun, bload, ld_wr, brk;
    logic [31:0]   w_ins;
    logic          cpu_en, cpu_rst, im_we, ld_full;
    logic [AW-1:0] im_wa;
    logic [31:0]   im_wd;
    logic [1:0]    state;
    logic [15:0]   icnt;

    mips_run_ctrl #(
        .TICK_DIV (T),
        .IMEM_AW  (AW)
    ) dut (
        .CLK     (clk),
        .RST     (rst),
        .BSTEP   (bstep),
        .BRUN    (brun),
        .BLOAD   (bload),
        .LD_WR   (ld_wr),
        .W_Ins   (w_ins),
        .BRK     (brk),
        .CPU_EN  (cpu_en),
        .CPU_RST (cpu_rst),
        .IM_WE   (im_we),
        .IM_WA   (im_wa),
        .IM_WD   (im_wd),
        .LD_FULL (ld_full),
        .STATE   (state),
        .ICNT    (icnt)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at t=%0t", name, act, exp, $time);
        end
    endtask

    // ------------------------------------------------------------------
    // Reference model: state names as plain ints, RUN pacing computed from
    // the age of the RUN episode, load address as an int modulo DEPTH.
    // ------------------------------------------------------------------
    typedef struct {
        int          cyc;
        int          addr;
        logic [31:0] data;
        bit          full;
    } wr_t;

    int          q_en[$];
    wr_t         q_wr[$];
    int          cyc       = 0;
    bit          started   = 0;
    int          m_state   = 0;   // 0 idle, 1 run, 2 halt, 3 load
    int          run_start = 0;
    int          m_addr    = 0;
    bit          m_full    = 0;
    bit          m_cpu_rst = 0;
    int          m_wa      = 0;
    logic [31:0] m_wd      = 0;
    int          m_icnt    = 0;
    bit          m_en;

    always @(posedge clk) begin
        cyc++;
        started = 1;
        m_en    = 0;
        if (rst) begin
            m_state = 0; m_addr = 0; m_full = 0; m_cpu_rst = 0;
            m_wa = 0; m_wd = 0; m_icnt = 0;
        end else begin
            if (bload) begin
                if (m_state == 3) m_state = 0;
                else begin
                    m_state = 3; m_addr = 0; m_full = 0; m_icnt = 0;
                end
            end else begin
                case (m_state)
                    0: if (brun) begin
                           m_state = 1; run_start = cyc;
                       end else if (bstep) begin
                           if (brk) m_state = 2; else m_en = 1;
                       end
                    1: if (brun) m_state = 0;
                       else if (((cyc - run_start) % T) == 0) begin
                           if (brk) m_state = 2; else m_en = 1;
                       end
                    3: if (ld_wr && !m_full) begin
                           wr_t w;
                           w.cyc  = cyc;
                           w.addr = m_addr;
                           w.data = w_ins;
                           w.full = (m_addr == DEPTH - 1);
                           q_wr.push_back(w);
                           m_wa   = m_addr;
                           m_wd   = w_ins;
                           m_full = w.full;
                           m_addr = (m_addr + 1) % DEPTH;
                       end
                    default: ;
                endcase
            end
            m_cpu_rst = (m_state == 3);
            if (m_en) begin
                q_en.push_back(cyc);
                if (m_icnt < 16'hFFFF) m_icnt++;
            end
        end
    end

    // ------------------------------------------------------------------
    // Monitor
    // ------------------------------------------------------------------
    always @(negedge clk) begin
        if (started) begin
            while (q_en.size() != 0 && q_en[0] < cyc) begin
                check("cpu_en_missing_at_cycle", 32'(cyc), 32'(q_en.pop_front()));
            end
            if (cpu_en) begin
                if (q_en.size() == 0) check("cpu_en_spurious", 32'(cpu_en), 32'(0));
                else                  check("cpu_en_cycle", 32'(cyc), 32'(q_en.pop_front()));
            end
            while (q_wr.size() != 0 && q_wr[0].cyc < cyc) begin
                wr_t lost;
                lost = q_wr.pop_front();
                check("im_we_missing_at_cycle", 32'(cyc), 32'(lost.cyc));
            end
            if (im_we) begin
                if (q_wr.size() == 0) check("im_we_spurious", 32'(im_we), 32'(0));
                else begin
                    wr_t w;
                    w = q_wr.pop_front();
                    check("im_we_cycle", 32'(cyc), 32'(w.cyc));
                    check("im_wa", 32'(im_wa), 32'(w.addr));
                    check("im_wd", im_wd, w.data);
                    check("ld_full_with_we", 32'(ld_full), 32'(w.full));
                end
            end
            check("state",   32'(state),   32'(m_state));
            check("cpu_rst", 32'(cpu_rst), 32'(m_cpu_rst));
            check("ld_full", 32'(ld_full), 32'(m_full));
            check("icnt",    32'(icnt),    32'(m_icnt));
            check("im_wa_hold", 32'(im_wa), 32'(m_wa));
            check("im_wd_hold", im_wd, m_wd);
        end
    end

    // ------------------------------------------------------------------
    // Stimulus
    // ------------------------------------------------------------------
    task automatic drive(input bit s, input bit r, input bit l, input bit w,
                         input logic [31:0] d);
        bstep = s; brun = r; bload = l; ld_wr = w; w_ins = d;
        @(posedge clk); #1;
        bstep = 0; brun = 0; bload = 0; ld_wr = 0;
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk); #1;
        end
    endtask

    initial begin
        #200_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        bit          s, r, l, w, prev;
        int          p;
        rst = 1; bstep = 0; brun = 0; bload = 0; ld_wr = 0; brk = 0; w_ins = 0;
        idle(3);
        check("reset_state", 32'(state), 32'(0));
        check("reset_icnt",  32'(icnt),  32'(0));
        rst = 0;

        // Three single steps.
        for (int i = 0; i < 3; i++) begin
            drive(1, 0, 0, 0, 0);
            idle(4);
        end
        check("steps_icnt",  32'(icnt),  32'(3));
        check("steps_state", 32'(state), 32'(0));

        // Free run for 20 cycles: five paced enables.
        drive(0, 1, 0, 0, 0);
        idle(20);
        drive(0, 1, 0, 0, 0);
        idle(10);
        check("run_icnt",  32'(icnt),  32'(8));
        check("run_state", 32'(state), 32'(0));

        // Break before the second terminal count.
        drive(0, 1, 0, 0, 0);
        idle(5);
        brk = 1;
        idle(6);
        check("brk_state", 32'(state), 32'(2));
        check("brk_icnt",  32'(icnt),  32'(9));
        brk = 0;
        drive(1, 0, 0, 0, 0); idle(3);
        drive(0, 1, 0, 0, 0); idle(8);
        check("halt_sticky_state", 32'(state), 32'(2));
        check("halt_sticky_icnt",  32'(icnt),  32'(9));

        // Load five words into a four-word memory.
        drive(0, 0, 1, 0, 0); idle(1);
        check("load_icnt_cleared", 32'(icnt), 32'(0));
        for (int i = 1; i <= 5; i++) begin
            drive(0, 0, 0, 1, 32'(i * 'h11));
            idle(1);
        end
        check("load_full", 32'(ld_full), 32'(1));
        check("load_last_wd", im_wd, 32'h44);
        drive(0, 0, 1, 0, 0); idle(2);
        check("unload_state",   32'(state),   32'(0));
        check("unload_cpu_rst", 32'(cpu_rst), 32'(0));

        // BLOAD outranks BSTEP; reset during a write.
        drive(1, 0, 1, 0, 0); idle(2);
        check("prio_state", 32'(state), 32'(3));
        drive(0, 0, 0, 1, 32'hCAFE_0001); idle(1);
        rst = 1;
        drive(0, 0, 0, 1, 32'hDEAD_BEEF);
        rst = 0;
        check("rst_state", 32'(state),   32'(0));
        check("rst_crst",  32'(cpu_rst), 32'(0));
        check("rst_wa",    32'(im_wa),   32'(0));
        idle(2);

        // Counter saturation.
        dut.r_icnt = 16'hFFFE;
        m_icnt     = 16'hFFFE;
        drive(1, 0, 0, 0, 0); idle(4);
        check("sat_reach", 32'(icnt), 32'hFFFF);
        drive(1, 0, 0, 0, 0); idle(4);
        check("sat_hold",  32'(icnt), 32'hFFFF);

        // Randomised pulses; the debouncer never emits back-to-back pulses.
        prev = 0;
        for (int i = 0; i < 900; i++) begin
            s = 0; r = 0; l = 0; w = 0;
            brk = ($urandom_range(0, 7) == 0);
            if (!prev) begin
                p = $urandom_range(0, 99);
                if (p < 5)       s = 1;
                else if (p < 8)  r = 1;
                else if (p < 12) l = 1;
                else if (p < 45) w = 1;
                if (p < 45 && $urandom_range(0, 9) == 0) begin
                    case ($urandom_range(0, 3))
                        0:       s = 1;
                        1:       r = 1;
                        2:       l = 1;
                        default: w = 1;
                    endcase
                end
            end
            rst  = ($urandom_range(0, 299) == 0);
            prev = s | r | l | w;
            drive(s, r, l, w, $urandom());
            rst = 0;
        end
        brk = 0;
        idle(T + 4);
        check("en_queue_drained", 32'(q_en.size()), 32'(0));
        check("wr_queue_drained", 32'(q_wr.size()), 32'(0));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule : tb_mips_run_ctrl
`default_nettype wire
